// File: rtl/win7_pkg.sv
// Shared definitions for the 7x7 neighbourhood pipeline.
//   WIN_RADIUS  : half-width of the 7x7 window (border rows/cols without a result)
//   wr_state_t  : result-writer FSM states
//   calc_pad()  : raster distance from frame start to the first valid window centre
//   calc_n()    : pixels per frame
package win7_pkg;

    localparam int WIN_RADIUS = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL_TOP = 3'd1,
        S_STREAM   = 3'd2,
        S_FILL_BOT = 3'd3,
        S_DONE     = 3'd4
    } wr_state_t;

    function automatic int calc_pad(input int img_w);
        return WIN_RADIUS * img_w + WIN_RADIUS;
    endfunction

    function automatic int calc_n(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

endpackage

// File: rtl/raster_addr_counter.sv
// Raster write-address counter with a column counter that tracks addr mod IMG_W.
// Ports:
//   clk, rst      : clock, async active-high reset
//   load          : restart at address 0 / column 0 (wins over en)
//   en            : advance one pixel
//   addr          : current raster address
//   col           : current column (addr mod IMG_W)
//   tc_top        : addr is the last top-border address (PAD-1)
//   tc_stream     : addr is the last streamed address (N-PAD-1)
//   tc_frame      : addr is the last frame address (N-1)
//   col_interior  : column has a valid 7x7 window (not within WIN_RADIUS of an edge)
module raster_addr_counter
    import win7_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [COL_W-1:0]  col,
    output logic              tc_top,
    output logic              tc_stream,
    output logic              tc_frame,
    output logic              col_interior
);

    localparam logic [ADDR_W-1:0] TOP_LAST    = ADDR_W'(calc_pad(IMG_W) - 1);
    localparam logic [ADDR_W-1:0] STREAM_LAST = ADDR_W'(calc_n(IMG_W, IMG_H) - calc_pad(IMG_W) - 1);
    localparam logic [ADDR_W-1:0] FRAME_LAST  = ADDR_W'(calc_n(IMG_W, IMG_H) - 1);
    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_LO      = COL_W'(WIN_RADIUS);
    localparam logic [COL_W-1:0]  COL_HI      = COL_W'(IMG_W - 1 - WIN_RADIUS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            col  <= '0;
        end else if (load) begin
            addr <= '0;
            col  <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
            // wrap compare instead of a modulo keeps the column path divider-free
            col  <= (col == COL_LAST) ? '0 : col + 1'b1;
        end
    end

    assign tc_top       = (addr == TOP_LAST);
    assign tc_stream    = (addr == STREAM_LAST);
    assign tc_frame     = (addr == FRAME_LAST);
    assign col_interior = (col >= COL_LO) && (col <= COL_HI);

endmodule

// File: rtl/window_result_writer_7x7.sv
// Writes one full W x H result frame to a single-port RAM in raster order.
// Border addresses (no valid 7x7 window) receive BORDER_VAL so that every
// address is written exactly once per frame.
// Ports:
//   clk, rst    : clock, async active-high reset (aborts a frame in progress)
//   start       : frame start pulse, aligned with the first raw pixel upstream
//   in_valid    : window result beat valid
//   in_data     : window result for the current centre pixel
//   mem_we      : RAM write enable
//   mem_addr    : RAM write address
//   mem_wdata   : RAM write data
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last write
//   err         : sticky protocol error, cleared by rst or an accepted start
//
// state      | meaning
// S_IDLE     | waiting for start
// S_FILL_TOP | writing BORDER_VAL to 0..PAD-1, one per cycle
// S_STREAM   | one write per in_valid beat, PAD..N-PAD-1
// S_FILL_BOT | writing BORDER_VAL to N-PAD..N-1, one per cycle
// S_DONE     | frame_done pulse, busy drops, back to idle
module window_result_writer_7x7
    import win7_pkg::*;
#(
    parameter int                IMG_W      = 512,
    parameter int                IMG_H      = 512,
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 18,
    parameter logic [DATA_W-1:0] BORDER_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int COL_W = $clog2(IMG_W);

    wr_state_t         state, state_nxt;
    logic              cnt_load, cnt_en;
    logic [ADDR_W-1:0] cnt_addr;
    logic [COL_W-1:0]  cnt_col;
    logic              tc_top, tc_stream, tc_frame, col_interior;

    logic              we_nxt, busy_nxt, done_nxt, err_nxt, proto_err;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    raster_addr_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .load         (cnt_load),
        .en           (cnt_en),
        .addr         (cnt_addr),
        .col          (cnt_col),
        .tc_top       (tc_top),
        .tc_stream    (tc_stream),
        .tc_frame     (tc_frame),
        .col_interior (col_interior)
    );

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start)                 state_nxt = S_FILL_TOP;
            S_FILL_TOP: if (tc_top)                state_nxt = S_STREAM;
            S_STREAM:   if (in_valid && tc_stream) state_nxt = S_FILL_BOT;
            S_FILL_BOT: if (tc_frame)              state_nxt = S_DONE;
            S_DONE:                                state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        // beats are only legal while streaming; start only while idle
        proto_err = (in_valid && (state != S_STREAM)) || (start && (state != S_IDLE));
        err_nxt   = err;
        if ((state == S_IDLE) && start) begin
            err_nxt = 1'b0;
        end
        if (proto_err) begin
            err_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            S_FILL_TOP, S_FILL_BOT: begin
                we_nxt    = 1'b1;
                addr_nxt  = cnt_addr;
                wdata_nxt = BORDER_VAL;
                cnt_en    = 1'b1;
            end
            S_STREAM: begin
                if (in_valid) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = cnt_addr;
                    // columns near the row edges hold windows that straddle two rows
                    wdata_nxt = col_interior ? in_data : BORDER_VAL;
                    cnt_en    = 1'b1;
                end
            end
            S_DONE: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_window_result_writer_7x7.sv
module tb_window_result_writer_7x7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- 16x16 instance ----------------
    logic       start16, iv16;
    logic [7:0] id16;
    logic       we16, busy16, fd16, err16;
    logic [7:0] addr16, wd16;

    window_result_writer_7x7 #(
        .IMG_W(16), .IMG_H(16), .DATA_W(8), .ADDR_W(8), .BORDER_VAL(8'h00)
    ) dut16 (
        .clk(clk), .rst(rst), .start(start16), .in_valid(iv16), .in_data(id16),
        .mem_we(we16), .mem_addr(addr16), .mem_wdata(wd16),
        .busy(busy16), .frame_done(fd16), .err(err16)
    );

    // ---------------- 512x8 instance (wide-row smoke) ----------------
    logic        start5, iv5;
    logic [7:0]  id5;
    logic        we5, busy5, fd5, err5;
    logic [11:0] addr5;
    logic [7:0]  wd5;

    window_result_writer_7x7 #(
        .IMG_W(512), .IMG_H(8), .DATA_W(8), .ADDR_W(12), .BORDER_VAL(8'h00)
    ) dut5 (
        .clk(clk), .rst(rst), .start(start5), .in_valid(iv5), .in_data(id5),
        .mem_we(we5), .mem_addr(addr5), .mem_wdata(wd5),
        .busy(busy5), .frame_done(fd5), .err(err5)
    );

    // ---------------- scoreboard / monitors ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q16[$];
    logic [7:0] ram16 [256];
    int         wcnt16[256];
    int         we_total16 = 0;
    int         fd_cnt16 = 0;
    wr_t        e16;

    always @(negedge clk) begin
        if (!rst) begin
            if (we16) begin
                we_total16++;
                wcnt16[addr16]++;
                ram16[addr16] = wd16;
                if (exp_q16.size() == 0) begin
                    check("unexpected_write16", 32'(addr16), 32'hFFFF);
                end else begin
                    e16 = exp_q16.pop_front();
                    check("wr_addr16", 32'(addr16), 32'(e16.a));
                    check("wr_data16", 32'(wd16), 32'(e16.d));
                end
            end
            if (fd16) fd_cnt16++;
        end
    end

    int         we_total5 = 0;
    int         exp_addr5 = 0;
    logic [11:0] last_addr5 = '0;

    always @(negedge clk) begin
        if (!rst && we5) begin
            we_total5++;
            check("smoke_addr", 32'(addr5), 32'(exp_addr5));
            exp_addr5++;
            last_addr5 = addr5;
        end
    end

    // PAD = 51, N = 256; stream beat b lands at address 51 + b
    function automatic logic [7:0] exp_val16(input int a);
        int col;
        col = a % 16;
        if (a < 51 || a >= 205) return 8'h00;
        if (col < 3 || col > 12) return 8'h00;
        return 8'(a - 51);
    endfunction

    task automatic prep_frame16();
        wr_t w;
        exp_q16.delete();
        for (int i = 0; i < 256; i++) begin
            wcnt16[i] = 0;
            ram16[i]  = 8'h5A;
            w.a = 8'(i);
            w.d = exp_val16(i);
            exp_q16.push_back(w);
        end
        we_total16 = 0;
        fd_cnt16   = 0;
    endtask

    task automatic run_frame16(input bit gapped, input bit early, input bit extra, input bit restart);
        int  beat;
        int  bad;
        bit  seen;
        prep_frame16();
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        for (int c = 1; c < 60; c++) begin
            if (early && c == 10) begin
                iv16 = 1'b1;
                id16 = 8'hAA;
            end else begin
                iv16 = 1'b0;
            end
            start16 = (restart && c == 20);
            if (c == 15) begin
                check("busy_fill_top", 32'(busy16), 32'd1);
                if (early) check("err_early", 32'(err16), 32'd1);
            end
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        start16 = 1'b0;
        beat = 0;
        while (beat < 154) begin
            if (gapped && $urandom_range(1, 0) == 0) begin
                iv16 = 1'b0;
            end else begin
                iv16 = 1'b1;
                id16 = 8'(beat);
                beat++;
            end
            @(posedge clk); #1;
        end
        if (extra) begin
            iv16 = 1'b1;
            id16 = 8'h77;
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        check("busy_fill_bot", 32'(busy16), 32'd1);
        seen = 1'b0;
        for (int g = 0; g < 200 && !seen; g++) begin
            @(negedge clk);
            if (fd16) seen = 1'b1;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy16), 32'd0);
        check("fd_pulses", 32'(fd_cnt16), 32'd1);
        check("err_end", 32'(err16), 32'(early | extra | restart));
        check("we_total16", 32'(we_total16), 32'd256);
        check("queue_empty16", 32'(exp_q16.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wcnt16[i] != 1) bad++;
        check("addr_written_once", 32'(bad), 32'd0);
        check("ram51",  32'(ram16[51]),  32'd0);
        check("ram52",  32'(ram16[52]),  32'd1);
        check("ram60",  32'(ram16[60]),  32'd9);
        check("ram63",  32'(ram16[63]),  32'd0);
        check("ram64",  32'(ram16[64]),  32'd0);
        check("ram67",  32'(ram16[67]),  32'd16);
        check("ram204", 32'(ram16[204]), 32'd153);
        check("ram205", 32'(ram16[205]), 32'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start16 = 1'b0; iv16 = 1'b0; id16 = '0;
        start5  = 1'b0; iv5  = 1'b0; id5  = '0;
        repeat (3) @(negedge clk);
        check("rst_we",    32'(we16),   32'd0);
        check("rst_addr",  32'(addr16), 32'd0);
        check("rst_wdata", 32'(wd16),   32'd0);
        check("rst_busy",  32'(busy16), 32'd0);
        check("rst_done",  32'(fd16),   32'd0);
        check("rst_err",   32'(err16),  32'd0);
        check("rst_we5",   32'(we5),    32'd0);
        check("rst_busy5", 32'(busy5),  32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // continuous, gapped, early beat, extra beat, start while busy
        run_frame16(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame16(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame16(1'b0, 1'b1, 1'b0, 1'b0);
        run_frame16(1'b0, 1'b0, 1'b1, 1'b0);
        run_frame16(1'b0, 1'b0, 1'b0, 1'b1);

        // reset in the middle of STREAM
        prep_frame16();
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        for (int b = 0; b < 20; b++) begin
            iv16 = 1'b1;
            id16 = 8'(b);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_we",   32'(we16),   32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        iv16 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_q16.delete();
        // a beat in IDLE only raises err, proving the FSM went back to idle
        iv16 = 1'b1; id16 = 8'h33;
        @(posedge clk); #1 iv16 = 1'b0;
        @(negedge clk);
        check("idle_beat_err", 32'(err16), 32'd1);
        check("idle_beat_busy", 32'(busy16), 32'd0);
        run_frame16(1'b0, 1'b0, 1'b0, 1'b0);

        // wide-row smoke: PAD = 1539, N = 4096
        @(posedge clk); #1 start5 = 1'b1;
        @(posedge clk); #1 start5 = 1'b0;
        repeat (1600) begin @(posedge clk); #1; end
        check("smoke_idle_before", 32'(we5), 32'd0);
        iv5 = 1'b1; id5 = 8'hC3;
        @(posedge clk); #1;
        check("smoke_first_we",   32'(we5),   32'd1);
        check("smoke_first_addr", 32'(addr5), 32'd1539);
        check("smoke_first_data", 32'(wd5),   32'hC3);
        for (int b = 1; b < 1018; b++) begin
            id5 = 8'(b);
            @(posedge clk); #1;
        end
        iv5 = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 2000 && !seen; g++) begin
            @(negedge clk);
            if (fd5) seen = 1'b1;
        end
        check("smoke_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("smoke_last_addr", 32'(last_addr5), 32'd4095);
        check("smoke_we_total",  32'(we_total5),  32'd4096);
        check("smoke_busy_low",  32'(busy5),      32'd0);
        check("smoke_err",       32'(err5),       32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
